// File: rtl/udp_tx_arbiter.sv
// Packet-granular round-robin arbiter for the shared UDP user-TX stream.
// Two sources, whole-packet grants, truncation with drain, per-port counters.
module udp_tx_arbiter #(
   parameter int unsigned MAX_BEATS = 375,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             sclk,
   input  logic             reset,
   input  logic [1:0]       port_en,
   input  logic             s0_tvalid,
   input  logic [31:0]      s0_tdata,
   input  logic [63:0]      s0_tuser,
   input  logic [3:0]       s0_tkeep,
   input  logic             s0_tlast,
   output logic             s0_tready,
   input  logic             s1_tvalid,
   input  logic [31:0]      s1_tdata,
   input  logic [63:0]      s1_tuser,
   input  logic [3:0]       s1_tkeep,
   input  logic             s1_tlast,
   output logic             s1_tready,
   output logic             m_tvalid,
   output logic [31:0]      m_tdata,
   output logic [63:0]      m_tuser,
   output logic [3:0]       m_tkeep,
   output logic             m_tlast,
   input  logic             m_tready,
   output logic [1:0]       grant,
   output logic             trunc_pulse,
   output logic [CNT_W-1:0] pkt_cnt0,
   output logic [CNT_W-1:0] pkt_cnt1,
   output logic [CNT_W-1:0] trunc_cnt
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1, DRAIN} state_e;

   state_e           state_q, state_d;
   logic             rr_last_q, rr_last_d;
   logic             drain_src_q, drain_src_d;
   logic [15:0]      beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
   logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;
   logic [CNT_W-1:0] trunc_cnt_q, trunc_cnt_d;
   logic             trunc_pulse_q;

   logic [1:0] req;
   logic       sel, gnt_act, sv, sl, dv, dl;
   logic       at_max, beat, pkt_end, trunc, done;

   assign req     = {s1_tvalid & port_en[1], s0_tvalid & port_en[0]};
   assign sel     = (state_q == GNT1);
   assign gnt_act = (state_q == GNT0) | (state_q == GNT1);
   assign sv      = sel ? s1_tvalid : s0_tvalid;
   assign sl      = sel ? s1_tlast : s0_tlast;
   assign dv      = drain_src_q ? s1_tvalid : s0_tvalid;
   assign dl      = drain_src_q ? s1_tlast : s0_tlast;
   assign at_max  = (beat_cnt_q == 16'(MAX_BEATS - 1));
   assign beat    = gnt_act & sv & m_tready;
   assign pkt_end = beat & sl;
   assign trunc   = beat & ~sl & at_max;
   assign done    = pkt_end | trunc;

   always_ff @(posedge sclk) begin
      if (reset) begin
         state_q       <= IDLE;
         rr_last_q     <= 1'b1;
         drain_src_q   <= 1'b0;
         beat_cnt_q    <= '0;
         pkt_cnt0_q    <= '0;
         pkt_cnt1_q    <= '0;
         trunc_cnt_q   <= '0;
         trunc_pulse_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_last_q     <= rr_last_d;
         drain_src_q   <= drain_src_d;
         beat_cnt_q    <= beat_cnt_d;
         pkt_cnt0_q    <= pkt_cnt0_d;
         pkt_cnt1_q    <= pkt_cnt1_d;
         trunc_cnt_q   <= trunc_cnt_d;
         trunc_pulse_q <= trunc;
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_last_d   = rr_last_q;
      drain_src_d = drain_src_q;
      beat_cnt_d  = beat_cnt_q;
      pkt_cnt0_d  = pkt_cnt0_q + CNT_W'(done & ~sel);
      pkt_cnt1_d  = pkt_cnt1_q + CNT_W'(done & sel);
      trunc_cnt_d = trunc_cnt_q + CNT_W'(trunc);
      unique case (state_q)
         IDLE: begin
            if (req == 2'b11)
               state_d = rr_last_q ? GNT0 : GNT1;
            else if (req[0])
               state_d = GNT0;
            else if (req[1])
               state_d = GNT1;
         end
         GNT0, GNT1: begin
            if (pkt_end) begin
               rr_last_d  = sel;
               beat_cnt_d = '0;
               // Zero-bubble handover, other port first
               if (req[~sel])
                  state_d = sel ? GNT0 : GNT1;
               else if (!req[sel])
                  state_d = IDLE;
            end else if (trunc) begin
               rr_last_d   = sel;
               beat_cnt_d  = '0;
               drain_src_d = sel;
               state_d     = DRAIN;
            end else if (beat) begin
               beat_cnt_d = beat_cnt_q + 16'd1;
            end else if (beat_cnt_q == '0 && !sv) begin
               // No packet started: release so the other port is not starved
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (dv & dl)
               state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      m_tvalid  = 1'b0;
      m_tdata   = '0;
      m_tuser   = '0;
      m_tkeep   = '0;
      m_tlast   = 1'b0;
      s0_tready = 1'b0;
      s1_tready = 1'b0;
      grant     = {state_q == GNT1, state_q == GNT0};
      unique case (state_q)
         GNT0: begin
            m_tvalid  = s0_tvalid;
            m_tdata   = s0_tdata;
            m_tuser   = s0_tuser;
            m_tkeep   = s0_tkeep;
            m_tlast   = s0_tlast | at_max;
            s0_tready = m_tready;
         end
         GNT1: begin
            m_tvalid  = s1_tvalid;
            m_tdata   = s1_tdata;
            m_tuser   = s1_tuser;
            m_tkeep   = s1_tkeep;
            m_tlast   = s1_tlast | at_max;
            s1_tready = m_tready;
         end
         DRAIN: begin
            s0_tready = ~drain_src_q;
            s1_tready = drain_src_q;
         end
         default: ;
      endcase
   end

   assign trunc_pulse = trunc_pulse_q;
   assign pkt_cnt0    = pkt_cnt0_q;
   assign pkt_cnt1    = pkt_cnt1_q;
   assign trunc_cnt   = trunc_cnt_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Randomized bench for udp_tx_arbiter against a packet-level behavioural model.
// Sources generate numbered packets; model tracks owner, drain and counters.
module tb_udp_tx_arbiter;

   localparam int MAXB = 4;
   localparam int CW   = 16;

   logic          sclk = 1'b0;
   logic          reset;
   logic [1:0]    port_en;
   logic          s0_tvalid, s1_tvalid, s0_tlast, s1_tlast;
   logic [31:0]   s0_tdata, s1_tdata, m_tdata;
   logic [63:0]   s0_tuser, s1_tuser, m_tuser;
   logic [3:0]    s0_tkeep, s1_tkeep, m_tkeep;
   logic          s0_tready, s1_tready;
   logic          m_tvalid, m_tlast, m_tready;
   logic [1:0]    grant;
   logic          trunc_pulse;
   logic [CW-1:0] pkt_cnt0, pkt_cnt1, trunc_cnt;

   always #5 sclk = ~sclk;

   udp_tx_arbiter #(.MAX_BEATS(MAXB), .CNT_W(CW)) dut (
      .sclk(sclk), .reset(reset), .port_en(port_en),
      .s0_tvalid(s0_tvalid), .s0_tdata(s0_tdata), .s0_tuser(s0_tuser),
      .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
      .s1_tvalid(s1_tvalid), .s1_tdata(s1_tdata), .s1_tuser(s1_tuser),
      .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
      .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tuser(m_tuser),
      .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tready(m_tready),
      .grant(grant), .trunc_pulse(trunc_pulse),
      .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .trunc_cnt(trunc_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Source packet generators
   int       slen[2], sbeat[2], spid[2];
   bit       sv[2];
   bit [3:0] skeep[2];
   int       vprob, rprob;
   bit [1:0] en_v;

   // Model state: owner -1 = nobody
   int own, dsrc, rr, bcnt, tc;
   bit drn, tp;
   int pc[2];

   function automatic bit slast(int p);
      return sbeat[p] == slen[p] - 1;
   endfunction

   function automatic logic [31:0] dat(int p);
      return {p[0], spid[p][14:0], sbeat[p][15:0]};
   endfunction

   function automatic logic [63:0] usr(int p);
      return {32'(spid[p]), 16'(p), 16'(slen[p])};
   endfunction

   task automatic new_pkt(int p);
      slen[p]  = $urandom_range(1, 7);
      sbeat[p] = 0;
      spid[p]++;
      skeep[p] = 4'($urandom_range(1, 15));
   endtask

   task automatic drive();
      s0_tvalid = sv[0];
      s0_tdata  = dat(0);
      s0_tuser  = usr(0);
      s0_tkeep  = skeep[0];
      s0_tlast  = slast(0);
      s1_tvalid = sv[1];
      s1_tdata  = dat(1);
      s1_tuser  = usr(1);
      s1_tkeep  = skeep[1];
      s1_tlast  = slast(1);
   endtask

   task automatic model_reset();
      own = -1; drn = 0; dsrc = 0; rr = 1; bcnt = 0;
      pc[0] = 0; pc[1] = 0; tc = 0; tp = 0;
      sv[0] = 0; sv[1] = 0;
      new_pkt(0);
      new_pkt(1);
   endtask

   task automatic reset_pulse();
      @(negedge sclk);
      reset = 1'b1;
      @(posedge sclk);
      #1;
      chk("rst_grant", grant, 2'b00);
      chk("rst_m_tvalid", m_tvalid, 1'b0);
      chk("rst_s0_tready", s0_tready, 1'b0);
      chk("rst_s1_tready", s1_tready, 1'b0);
      chk("rst_m_tdata", m_tdata, 32'd0);
      chk("rst_m_tuser", m_tuser, 64'd0);
      chk("rst_m_tlast", m_tlast, 1'b0);
      chk("rst_trunc_pulse", trunc_pulse, 1'b0);
      chk("rst_pkt_cnt0", pkt_cnt0, 16'd0);
      chk("rst_pkt_cnt1", pkt_cnt1, 16'd0);
      chk("rst_trunc_cnt", trunc_cnt, 16'd0);
      model_reset();
      drive();
      @(negedge sclk);
      reset = 1'b0;
   endtask

   task automatic cycle();
      logic [1:0] e_grant;
      bit e_rdy[2], e_mv, e_last, beat, ntp, hs[2], req[2];
      int o;
      @(negedge sclk);
      port_en = en_v;
      for (int p = 0; p < 2; p++)
         if (!sv[p]) sv[p] = ($urandom_range(0, 99) < vprob);
      m_tready = ($urandom_range(0, 99) < rprob);
      drive();
      #1;
      e_grant = 2'b00; e_rdy[0] = 0; e_rdy[1] = 0; e_mv = 0; e_last = 0;
      if (own >= 0) begin
         e_mv = sv[own];
         e_last = slast(own) || (bcnt == MAXB - 1);
         e_rdy[own] = m_tready;
         e_grant = (own == 1) ? 2'b10 : 2'b01;
      end else if (drn) begin
         e_rdy[dsrc] = 1;
      end
      chk("grant", grant, e_grant);
      chk("s0_tready", s0_tready, e_rdy[0]);
      chk("s1_tready", s1_tready, e_rdy[1]);
      chk("m_tvalid", m_tvalid, e_mv);
      if (e_mv) begin
         chk("m_tlast", m_tlast, e_last);
         chk("m_tdata", m_tdata, dat(own));
         chk("m_tuser", m_tuser, usr(own));
         chk("m_tkeep", m_tkeep, skeep[own]);
      end
      chk("trunc_pulse", trunc_pulse, tp);
      chk("pkt_cnt0", pkt_cnt0, 16'(pc[0]));
      chk("pkt_cnt1", pkt_cnt1, 16'(pc[1]));
      chk("trunc_cnt", trunc_cnt, 16'(tc));
      for (int p = 0; p < 2; p++) begin
         hs[p]  = sv[p] && e_rdy[p];
         req[p] = sv[p] && en_v[p];
      end
      ntp = 0;
      if (own < 0 && !drn) begin
         if (req[0] && req[1]) own = (rr == 1) ? 0 : 1;
         else if (req[0]) own = 0;
         else if (req[1]) own = 1;
      end else if (own >= 0) begin
         o = own;
         beat = sv[o] && m_tready;
         if (beat && slast(o)) begin
            pc[o]++; rr = o; bcnt = 0;
            own = req[1-o] ? 1 - o : (req[o] ? o : -1);
         end else if (beat && bcnt == MAXB - 1) begin
            pc[o]++; tc++; ntp = 1; rr = o; bcnt = 0;
            drn = 1; dsrc = o; own = -1;
         end else if (beat) begin
            bcnt++;
         end else if (bcnt == 0 && !sv[o]) begin
            own = -1;
         end
      end else if (sv[dsrc] && slast(dsrc)) begin
         drn = 0;
      end
      tp = ntp;
      @(posedge sclk);
      for (int p = 0; p < 2; p++)
         if (hs[p]) begin
            if (slast(p)) new_pkt(p);
            else sbeat[p]++;
            sv[p] = 0;
         end
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      reset = 1'b1;
      port_en = 2'b11;
      m_tready = 1'b0;
      spid[0] = 0; spid[1] = 0;
      en_v = 2'b11;
      model_reset();
      drive();
      repeat (3) @(posedge sclk);
      reset_pulse();

      vprob = 60; rprob = 70;
      run(400);

      vprob = 100; rprob = 100;
      run(100);

      vprob = 80; rprob = 60;
      for (int i = 0; i < 200 && !(own >= 0 && bcnt == 1); i++) cycle();
      chk("reach_beat2", (own >= 0 && bcnt == 1), 1'b1);
      reset_pulse();
      vprob = 100; rprob = 100;
      run(2);
      chk("first_after_rst", pc[0] > 0 || own == 0, 1'b1);

      en_v = 2'b10; rprob = 50;
      run(100);
      for (int i = 0; i < 200 && !(own == 1 && bcnt > 0); i++) cycle();
      chk("reach_mid_pkt1", (own == 1 && bcnt > 0), 1'b1);
      en_v = 2'b00;
      run(30);
      chk("idle_after_disable", grant, 2'b00);

      en_v = 2'b11; vprob = 80; rprob = 90;
      run(300);
      reset_pulse();
      vprob = 50; rprob = 80;
      run(200);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
